// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data-memory responder built on a 128-bit line array.
// After reset the array is swept to zero one line per cycle. The block then serves
// loads, masked stores and swaps, answering one cycle after acceptance.
// Optional build macro: DMEM_RESPONDER_RAND_STALL_EN adds an LFSR-driven ready stall
// injector for verification. It is disabled by default.
module dmem_responder #(
    parameter int IDX_BITS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dcache_req_val,
    output logic         dcache_req_rdy,
    input  logic [3:0]   dcache_req_op,
    input  logic [31:0]  dcache_req_addr,
    input  logic [127:0] dcache_req_data,
    input  logic [15:0]  dcache_req_wmask,
    input  logic [14:0]  dcache_req_tag,
    output logic         dcache_resp_val,
    output logic [127:0] dcache_resp_data,
    output logic [14:0]  dcache_resp_tag,
    output logic         error
);

    localparam int LINES = 1 << IDX_BITS;
    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_SWAP  = 4'd2;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic                resp_val_q, resp_val_d;
    logic [127:0]        resp_data_q, resp_data_d;
    logic [14:0]         resp_tag_q, resp_tag_d;
    logic                error_q, error_d;

    logic [127:0]        mem_array [LINES];
    logic                mem_we;
    logic [IDX_BITS-1:0] mem_widx;
    logic [127:0]        mem_wdata;

    logic [IDX_BITS-1:0] req_idx;
    logic [127:0]        rd_line;
    logic                out_of_range;
    logic                op_legal;
    logic                req_rdy;
    logic                accept;
    logic                unused_addr_bits;

    assign req_idx          = dcache_req_addr[IDX_BITS+3:4];
    assign rd_line          = mem_array[req_idx];
    assign out_of_range     = |dcache_req_addr[31:IDX_BITS+4];
    assign op_legal         = (dcache_req_op == OP_LOAD) || (dcache_req_op == OP_STORE) ||
                              (dcache_req_op == OP_SWAP);
    assign accept           = dcache_req_val && req_rdy;
    assign unused_addr_bits = ^dcache_req_addr[3:0];

`ifdef DMEM_RESPONDER_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Advance the stall LFSR (taps 16,14,13,11) only while serving requests
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == RUN) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // LFSR register, reseeded on every reset so stall patterns are repeatable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign req_rdy = (state_q == RUN) && (lfsr_q[1:0] != 2'b00);
`else
    assign req_rdy = (state_q == RUN);
`endif

    assign dcache_req_rdy   = req_rdy;
    assign dcache_resp_val  = resp_val_q;
    assign dcache_resp_data = resp_data_q;
    assign dcache_resp_tag  = resp_tag_q;
    assign error            = error_q;

    // Next-state, clear sweep, request decode and response/write generation
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        resp_val_d  = 1'b0;
        resp_data_d = resp_data_q;
        resp_tag_d  = resp_tag_q;
        error_d     = error_q;
        mem_we      = 1'b0;
        mem_widx    = req_idx;
        mem_wdata   = rd_line;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_widx  = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + IDX_BITS'(1);
                if (clr_cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (!op_legal || out_of_range) begin
                        error_d = 1'b1;
                    end else begin
                        if (dcache_req_op != OP_LOAD) begin
                            mem_we = 1'b1;
                            for (int b = 0; b < 16; b++) begin
                                if (dcache_req_wmask[b]) begin
                                    mem_wdata[8*b +: 8] = dcache_req_data[8*b +: 8];
                                end
                            end
                        end
                        if (dcache_req_op != OP_STORE) begin
                            resp_val_d  = 1'b1;
                            resp_data_d = rd_line;
                            resp_tag_d  = dcache_req_tag;
                        end
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Control and response registers, all forced to their idle values by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT;
            clr_cnt_q   <= '0;
            resp_val_q  <= 1'b0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            resp_val_q  <= resp_val_d;
            resp_data_q <= resp_data_d;
            resp_tag_q  <= resp_tag_d;
            error_q     <= error_d;
        end
    end

    // Line array write port; contents are only ever cleared by the INIT sweep
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[mem_widx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (default build, IDX_BITS = 8).
// A line-array model plus a response queue supply every expected value.
module tb_dmem_responder;

   localparam int IDX_BITS = 8;
   localparam int LINES    = 1 << IDX_BITS;

   logic         clk;
   logic         reset;
   logic         dcache_req_val;
   logic         dcache_req_rdy;
   logic [3:0]   dcache_req_op;
   logic [31:0]  dcache_req_addr;
   logic [127:0] dcache_req_data;
   logic [15:0]  dcache_req_wmask;
   logic [14:0]  dcache_req_tag;
   logic         dcache_resp_val;
   logic [127:0] dcache_resp_data;
   logic [14:0]  dcache_resp_tag;
   logic         error;

   typedef struct packed {
      logic [127:0] data;
      logic [14:0]  tag;
   } resp_t;

   resp_t        expQueue[$];
   logic [127:0] model [LINES];
   logic         expError;
   logic [127:0] lastData;
   logic [14:0]  lastTag;
   int           nCompared    = 0;
   int           nMismatched  = 0;

   dmem_responder #(.IDX_BITS(IDX_BITS)) dut (
      .clk              (clk),
      .reset            (reset),
      .dcache_req_val   (dcache_req_val),
      .dcache_req_rdy   (dcache_req_rdy),
      .dcache_req_op    (dcache_req_op),
      .dcache_req_addr  (dcache_req_addr),
      .dcache_req_data  (dcache_req_data),
      .dcache_req_wmask (dcache_req_wmask),
      .dcache_req_tag   (dcache_req_tag),
      .dcache_resp_val  (dcache_resp_val),
      .dcache_resp_data (dcache_resp_data),
      .dcache_resp_tag  (dcache_resp_tag),
      .error            (error)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string name, input logic [127:0] obs, input logic [127:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < LINES; i++) model[i] = '0;
      expQueue.delete();
      expError = 1'b0;
      lastData = '0;
      lastTag  = '0;
   endtask

   // Called just after a clock edge: a queued entry means a response is due now
   task automatic checkOutput();
      resp_t r;
      checkVal("error", error, expError);
      if (expQueue.size() > 0) begin
         r = expQueue.pop_front();
         checkVal("resp_val", dcache_resp_val, 1);
         checkVal("resp_data", dcache_resp_data, r.data);
         checkVal("resp_tag", dcache_resp_tag, r.tag);
         lastData = r.data;
         lastTag  = r.tag;
      end else begin
         checkVal("resp_val_idle", dcache_resp_val, 0);
         checkVal("resp_data_hold", dcache_resp_data, lastData);
         checkVal("resp_tag_hold", dcache_resp_tag, lastTag);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic idle();
      dcache_req_val = 1'b0;
      stepCycle();
   endtask

   // Drives one request for one cycle and records its expected effect
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                input logic [127:0] data, input logic [15:0] wmask,
                                input logic [14:0] tag);
      logic [7:0]   idx;
      logic [127:0] oldLine;
      logic [127:0] newLine;
      resp_t        r;
      checkVal("req_rdy", dcache_req_rdy, 1);
      dcache_req_val   = 1'b1;
      dcache_req_op    = op;
      dcache_req_addr  = addr;
      dcache_req_data  = data;
      dcache_req_wmask = wmask;
      dcache_req_tag   = tag;
      idx = addr[11:4];
      if (op > 4'd2 || addr[31:12] != 20'h0) begin
         expError = 1'b1;
      end else begin
         oldLine = model[idx];
         newLine = oldLine;
         for (int b = 0; b < 16; b++) begin
            if (wmask[b]) newLine[8*b +: 8] = data[8*b +: 8];
         end
         if (op != 4'd0) model[idx] = newLine;
         if (op != 4'd1) begin
            r.data = oldLine;
            r.tag  = tag;
            expQueue.push_back(r);
         end
      end
      stepCycle();
   endtask

   // Counts cycles from the current point until ready rises, bounded
   task automatic waitInit(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (dcache_req_rdy !== 1'b1 && n < 1000);
      checkVal(name, n, 256);
   endtask

   initial begin
      reset            = 1'b0;
      dcache_req_val   = 1'b0;
      dcache_req_op    = '0;
      dcache_req_addr  = '0;
      dcache_req_data  = '0;
      dcache_req_wmask = '0;
      dcache_req_tag   = '0;
      clearModel();

      #2;
      checkVal("rst_rdy", dcache_req_rdy, 0);
      checkVal("rst_resp_val", dcache_resp_val, 0);
      checkVal("rst_resp_data", dcache_resp_data, 0);
      checkVal("rst_resp_tag", dcache_resp_tag, 0);
      checkVal("rst_error", error, 0);

      #20 reset = 1'b1;
      waitInit("init_cycles");

      applyStimulus(4'd0, 32'h0000_0FF0, '0, 16'h0000, 15'h7FF);
      idle();

      applyStimulus(4'd1, 32'h0000_0010, {16{8'hAA}}, 16'h00FF, 15'h0);
      applyStimulus(4'd0, 32'h0000_0010, '0, 16'h0000, 15'h123);
      idle();

      applyStimulus(4'd0, 32'h0000_0010, '0, 16'h0000, 15'd1);
      applyStimulus(4'd0, 32'h0000_0FF0, '0, 16'h0000, 15'd2);
      applyStimulus(4'd0, 32'h0000_0020, '0, 16'h0000, 15'd3);
      idle();

      applyStimulus(4'd1, 32'h0000_0020, {16{8'h11}}, 16'hFFFF, 15'd0);
      applyStimulus(4'd2, 32'h0000_0020, {16{8'h55}}, 16'hFFFF, 15'd4);
      applyStimulus(4'd0, 32'h0000_0020, '0, 16'h0000, 15'd5);
      idle();

      applyStimulus(4'd2, 32'h0000_0030, {$urandom, $urandom, $urandom, $urandom}, 16'hF00F, 15'd6);
      applyStimulus(4'd2, 32'h0000_003C, {$urandom, $urandom, $urandom, $urandom}, 16'h0FF0, 15'd7);
      applyStimulus(4'd0, 32'h0000_0030, '0, 16'h0000, 15'd8);
      idle();

      for (int i = 0; i < 12; i++) begin
         applyStimulus(4'($urandom_range(0, 2)), {24'h0, 4'($urandom_range(0, 7)), 4'h0},
                       {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 15'(16 + i));
      end
      idle();

      applyStimulus(4'd7, 32'h0000_0010, {16{8'hFF}}, 16'hFFFF, 15'd9);
      applyStimulus(4'd0, 32'h0001_0000, '0, 16'h0000, 15'd10);
      applyStimulus(4'd1, 32'h0001_0010, {16{8'hEE}}, 16'hFFFF, 15'd11);
      applyStimulus(4'd3, 32'h0000_0010, {16{8'hDD}}, 16'hFFFF, 15'd12);
      applyStimulus(4'd0, 32'h0000_0010, '0, 16'h0000, 15'd13);
      applyStimulus(4'd0, 32'h0000_0000, '0, 16'h0000, 15'd14);
      idle();

      checkVal("pend_rdy", dcache_req_rdy, 1);
      dcache_req_val   = 1'b1;
      dcache_req_op    = 4'd0;
      dcache_req_addr  = 32'h0000_0020;
      dcache_req_tag   = 15'h1AB;
      @(posedge clk);
      reset          = 1'b0;
      dcache_req_val = 1'b0;
      #1;
      clearModel();
      checkVal("pend_resp_val", dcache_resp_val, 0);
      checkVal("pend_rdy_low", dcache_req_rdy, 0);
      checkVal("pend_error_clr", error, 0);
      checkVal("pend_resp_data", dcache_resp_data, 0);
      checkVal("pend_resp_tag", dcache_resp_tag, 0);
      stepCycle();
      stepCycle();

      #3 reset = 1'b1;
      repeat (50) stepCycle();
      checkVal("midinit_rdy", dcache_req_rdy, 0);
      reset = 1'b0;
      #1;
      checkVal("midinit_rst_rdy", dcache_req_rdy, 0);
      stepCycle();
      #2 reset = 1'b1;
      waitInit("reinit_cycles");

      applyStimulus(4'd0, 32'h0000_0010, '0, 16'h0000, 15'd30);
      applyStimulus(4'd0, 32'h0000_0020, '0, 16'h0000, 15'd31);
      applyStimulus(4'd0, 32'h0000_0030, '0, 16'h0000, 15'd32);
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
